gray_decoder_checker: RTL and testbench

//  Receive end of the Gray-code counter interface. Samples a Gray-coded count

---
 rtl/gray_decoder_checker.sv | 141 ++++++++++++++
 tb/tb_gray_decoder_checker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_decoder_checker.sv
// gray_decoder_checker
//   Receive side of a Gray-code counter link. Each sample is registered, then
//   decoded to binary. Every valid decoded value is checked against the
//   previous one: a repeat or a +1 step (mod 2^WIDTH) is legal, anything else
//   is an illegal step. Illegal steps are counted, and a run of ERR_LIMIT
//   consecutive illegal steps latches the FAULT state until resync or clr.
//
// Ports
//   clk        rising-edge clock
//   clr        asynchronous active-high reset
//   gray_in    Gray-coded sample
//   valid_in   gray_in valid this cycle
//   resync     drop the reference and re-lock on the next valid sample
//   bin_out    decoded binary value (holds between valid samples)
//   bin_valid  1-cycle strobe, bin_out updated
//   step_err   1-cycle strobe, illegal step
//   wrap       1-cycle strobe, legal step from all-ones to zero
//   locked     checker is in LOCKED
//   fault      checker is in FAULT
//   err_count  saturating count of illegal steps

module gray_decoder_checker #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ERR_LIMIT = 3,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             valid_in,
    input  logic             resync,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             step_err,
    output logic             wrap,
    output logic             locked,
    output logic             fault,
    output logic [CNT_W-1:0] err_count
);

    // Wide enough to hold ERR_LIMIT itself.
    localparam int unsigned CONSEC_W = $clog2(ERR_LIMIT + 1);

    typedef enum logic [1:0] {StSync, StLocked, StFault} state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      g_q;
    logic                  v_q;
    logic [WIDTH-1:0]      b;
    logic [WIDTH-1:0]      prev_q, prev_d;
    logic [CONSEC_W-1:0]   consec_q, consec_d;
    logic [CNT_W-1:0]      cnt_d;
    logic                  step_err_d;
    logic                  wrap_d;

    // Binary bit i is the XOR of Gray bits i..WIDTH-1.
    always_comb begin
        b = '0;
        for (int i = 0; i < WIDTH; i++) begin
            b[i] = ^(g_q >> i);
        end
    end

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        consec_d   = consec_q;
        cnt_d      = err_count;
        step_err_d = 1'b0;
        wrap_d     = 1'b0;

        if (resync) begin
            // Takes priority over a coincident sample: no check, no reference load.
            state_d  = StSync;
            consec_d = '0;
        end else if (v_q) begin
            unique case (state_q)
                StSync: begin
                    prev_d  = b;
                    state_d = StLocked;
                end
                StLocked: begin
                    prev_d = b;
                    if (b == prev_q) begin
                        // Hold: legal, consecutive-error run is left as is.
                    end else if (b == prev_q + WIDTH'(1)) begin
                        consec_d = '0;
                        wrap_d   = (prev_q == '1);
                    end else begin
                        step_err_d = 1'b1;
                        if (err_count != '1) begin
                            cnt_d = err_count + CNT_W'(1);
                        end
                        consec_d = consec_q + CONSEC_W'(1);
                        if (consec_d == CONSEC_W'(ERR_LIMIT)) begin
                            state_d = StFault;
                        end
                    end
                end
                StFault: begin
                    // Decode only; checking is suspended until resync.
                end
                default: state_d = StSync;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            g_q       <= '0;
            v_q       <= 1'b0;
            state_q   <= StSync;
            prev_q    <= '0;
            consec_q  <= '0;
            bin_out   <= '0;
            bin_valid <= 1'b0;
            step_err  <= 1'b0;
            wrap      <= 1'b0;
            locked    <= 1'b0;
            fault     <= 1'b0;
            err_count <= '0;
        end else begin
            g_q       <= gray_in;
            v_q       <= valid_in;
            if (v_q) begin
                bin_out <= b;
            end
            bin_valid <= v_q;
            step_err  <= step_err_d;
            wrap      <= wrap_d;
            state_q   <= state_d;
            prev_q    <= prev_d;
            consec_q  <= consec_d;
            err_count <= cnt_d;
            // Registered alongside state_q, so these always mirror the current state.
            locked    <= (state_d == StLocked);
            fault     <= (state_d == StFault);
        end
    end

endmodule

// File: tb/tb_gray_decoder_checker.sv
// Testbench for gray_decoder_checker (WIDTH=4, ERR_LIMIT=3, CNT_W=3 so that
// counter saturation is reachable). Each table row is one driven cycle with
// the outputs expected two edges later. A row's resync flag is driven one
// cycle after the row so that it meets that row's sample in the decode stage.

module tb_gray_decoder_checker;

    logic       clk;
    logic       clr;
    logic [3:0] gray_in;
    logic       valid_in;
    logic       resync;
    logic [3:0] bin_out;
    logic       bin_valid;
    logic       step_err;
    logic       wrap;
    logic       locked;
    logic       fault;
    logic [2:0] err_count;

    gray_decoder_checker #(
        .WIDTH     (4),
        .ERR_LIMIT (3),
        .CNT_W     (3)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .gray_in   (gray_in),
        .valid_in  (valid_in),
        .resync    (resync),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .step_err  (step_err),
        .wrap      (wrap),
        .locked    (locked),
        .fault     (fault),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags = {bin_valid, step_err, wrap, locked, fault}
    typedef struct {
        int         id;
        logic [3:0] gray;
        logic       valid;
        logic       rs;
        logic [3:0] bin;
        logic [4:0] flags;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic rs_pending = 1'b0;

    function automatic void add(input logic [3:0] g, input logic v, input logic rs,
                                input logic [3:0] bin, input logic [4:0] flags,
                                input logic [2:0] cnt);
        vec_t r;
        r.id    = tbl.size();
        r.gray  = g;
        r.valid = v;
        r.rs    = rs;
        r.bin   = bin;
        r.flags = flags;
        r.cnt   = cnt;
        tbl.push_back(r);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_row(input vec_t e);
        string p;
        p = $sformatf("row%0d", e.id);
        chk({p, " bin_out"},   8'(bin_out),   8'(e.bin));
        chk({p, " bin_valid"}, 8'(bin_valid), 8'(e.flags[4]));
        chk({p, " step_err"},  8'(step_err),  8'(e.flags[3]));
        chk({p, " wrap"},      8'(wrap),      8'(e.flags[2]));
        chk({p, " locked"},    8'(locked),    8'(e.flags[1]));
        chk({p, " fault"},     8'(fault),     8'(e.flags[0]));
        chk({p, " err_count"}, 8'(err_count), 8'(e.cnt));
    endtask

    // One clock: drive, push expectation, compare whatever output is now due.
    task automatic cycle(input vec_t v, input bit push);
        vec_t e;
        gray_in  = push ? v.gray : 4'b0000;
        valid_in = push ? v.valid : 1'b0;
        resync   = rs_pending;
        rs_pending = push ? v.rs : 1'b0;
        if (push) sb.push_back(v);
        @(posedge clk);
        #1;
        if ((push && sb.size() == 2) || (!push && sb.size() > 0)) begin
            e = sb.pop_front();
            check_row(e);
        end
    endtask

    task automatic run_table();
        vec_t dummy;
        dummy = tbl[0];
        foreach (tbl[i]) cycle(tbl[i], 1'b1);
        cycle(dummy, 1'b0);
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        tbl.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " bin_out"},   8'(bin_out),   8'h00);
        chk({tag, " bin_valid"}, 8'(bin_valid), 8'h00);
        chk({tag, " step_err"},  8'(step_err),  8'h00);
        chk({tag, " wrap"},      8'(wrap),      8'h00);
        chk({tag, " locked"},    8'(locked),    8'h00);
        chk({tag, " fault"},     8'(fault),     8'h00);
        chk({tag, " err_count"}, 8'(err_count), 8'h00);
    endtask

    initial begin
        clr      = 1'b1;
        gray_in  = 4'b0000;
        valid_in = 1'b0;
        resync   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        clr = 1'b0;

        //   gray     v     rs    bin    flags(bv,err,wr,lk,ft) cnt
        // Counting 0..3
        add(4'b0000, 1'b1, 1'b0, 4'd0,  5'b10010, 3'd0);
        add(4'b0001, 1'b1, 1'b0, 4'd1,  5'b10010, 3'd0);
        add(4'b0011, 1'b1, 1'b0, 4'd2,  5'b10010, 3'd0);
        add(4'b0010, 1'b1, 1'b0, 4'd3,  5'b10010, 3'd0);
        // Resync, then 15 -> 0 wrap
        add(4'b0000, 1'b0, 1'b1, 4'd3,  5'b00000, 3'd0);
        add(4'b1000, 1'b1, 1'b0, 4'd15, 5'b10010, 3'd0);
        add(4'b0000, 1'b1, 1'b0, 4'd0,  5'b10110, 3'd0);
        add(4'b0000, 1'b0, 1'b0, 4'd0,  5'b00010, 3'd0);
        // 1 -> 3 illegal, then 4 legal
        add(4'b0001, 1'b1, 1'b0, 4'd1,  5'b10010, 3'd0);
        add(4'b0010, 1'b1, 1'b0, 4'd3,  5'b11010, 3'd1);
        add(4'b0110, 1'b1, 1'b0, 4'd4,  5'b10010, 3'd1);
        // Three consecutive illegal steps -> FAULT
        add(4'b1101, 1'b1, 1'b0, 4'd9,  5'b11010, 3'd2);
        add(4'b0011, 1'b1, 1'b0, 4'd2,  5'b11010, 3'd3);
        add(4'b1010, 1'b1, 1'b0, 4'd12, 5'b11001, 3'd4);
        add(4'b0000, 1'b1, 1'b0, 4'd0,  5'b10001, 3'd4);
        // Resync and re-lock on 6, 7
        add(4'b0000, 1'b0, 1'b1, 4'd0,  5'b00000, 3'd4);
        add(4'b0101, 1'b1, 1'b0, 4'd6,  5'b10010, 3'd4);
        add(4'b0100, 1'b1, 1'b0, 4'd7,  5'b10010, 3'd4);
        // Resync, then repeated 2 with gaps (gap data must be ignored)
        add(4'b0000, 1'b0, 1'b1, 4'd7,  5'b00000, 3'd4);
        add(4'b0011, 1'b1, 1'b0, 4'd2,  5'b10010, 3'd4);
        add(4'b1111, 1'b0, 1'b0, 4'd2,  5'b00010, 3'd4);
        add(4'b0011, 1'b1, 1'b0, 4'd2,  5'b10010, 3'd4);
        add(4'b1010, 1'b0, 1'b0, 4'd2,  5'b00010, 3'd4);
        add(4'b0011, 1'b1, 1'b0, 4'd2,  5'b10010, 3'd4);
        add(4'b0011, 1'b1, 1'b0, 4'd2,  5'b10010, 3'd4);
        // Resync coinciding with a sample: decoded, not checked, not a reference
        add(4'b0010, 1'b1, 1'b1, 4'd3,  5'b10000, 3'd4);
        add(4'b1100, 1'b1, 1'b0, 4'd8,  5'b10010, 3'd4);
        add(4'b1101, 1'b1, 1'b0, 4'd9,  5'b10010, 3'd4);
        // Alternate errors/legal steps up to and past counter saturation
        add(4'b0000, 1'b1, 1'b0, 4'd0,  5'b11010, 3'd5);
        add(4'b0001, 1'b1, 1'b0, 4'd1,  5'b10010, 3'd5);
        add(4'b0111, 1'b1, 1'b0, 4'd5,  5'b11010, 3'd6);
        add(4'b0101, 1'b1, 1'b0, 4'd6,  5'b10010, 3'd6);
        add(4'b0000, 1'b1, 1'b0, 4'd0,  5'b11010, 3'd7);
        add(4'b0001, 1'b1, 1'b0, 4'd1,  5'b10010, 3'd7);
        add(4'b1111, 1'b1, 1'b0, 4'd10, 5'b11010, 3'd7);
        add(4'b1110, 1'b1, 1'b0, 4'd11, 5'b10010, 3'd7);
        run_table();

        // Asynchronous clear mid-cycle with a valid sample in flight
        gray_in  = 4'b0001;
        valid_in = 1'b1;
        resync   = 1'b0;
        @(posedge clk);
        #3;
        clr = 1'b1;
        #1;
        check_all_zero("async_clr");
        valid_in = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        sb.delete();
        rs_pending = 1'b0;

        // First sample after clear re-locks without error
        add(4'b0110, 1'b1, 1'b0, 4'd4,  5'b10010, 3'd0);
        add(4'b0111, 1'b1, 1'b0, 4'd5,  5'b10010, 3'd0);
        add(4'b0101, 1'b1, 1'b0, 4'd6,  5'b10010, 3'd0);
        run_table();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
